mac_readout: RTL and testbench
==============================

// Module: mac_readout
// PURPOSE
//  Sequencer and result reader for one mac neuron lane. On START it drives the mac
//  MAC_RST/MAC_EN controls: bias preload, then LEN enabled accumulate cycles.
//  It captures the 16-bit accumulator, requantizes it to a signed 8-bit activation and
//  queues it in a small FIFO with a valid/ready output toward the next layer's buffer.
// PARAMETERS
//  ACC_W      16  accumulator width (mac result)
//  OUT_W      8   activation width
//  LEN_W      10  width of LEN (max 2^LEN_W-1 products per neuron)
//  FIFO_DEPTH 4   output FIFO entries (power of 2, >=2)
// PORTS
//  CLKEXT     in   1      system clock, rising edge
//  RST        in   1      asynchronous active-high reset
//  START      in   1      1-cycle pulse: begin one neuron; ignored unless BUSY=0
//  LEN        in   LEN_W  number of products; sampled with START
//  SHIFT_IN   in   4      requant right shift 0..15; sampled with START
//  ACC_IN     in   ACC_W  mac result (signed)
//  MAC_RST    out  1      to mac RST_MAC: selects BIAS_IN preload
//  MAC_EN     out  1      to mac EN_MAC; high exactly one cycle per operand pair
//  BUSY       out  1      state != IDLE
//  OUT_DATA   out  OUT_W  FIFO head, signed, show-ahead
//  OUT_VALID  out  1      FIFO not empty
//  OUT_READY  in   1      consumer accepts head when OUT_VALID&OUT_READY
//  FULL       out  1      FIFO count == FIFO_DEPTH
// BEHAVIOUR
//  Reset: state IDLE, MAC_RST=0, MAC_EN=0, BUSY=0, FIFO empty (OUT_VALID=0, FULL=0),
//   OUT_DATA=0. Reset mid-neuron abandons it; no partial result is pushed.
//  FSM (registered outputs):
//   IDLE    -> PRELOAD on START (latch LEN, SHIFT_IN).
//   PRELOAD: MAC_RST=1 for 1 cycle; -> ACCUM if LEN>0, else -> CAPTURE.
//   ACCUM:  MAC_EN=1; down-counter from LEN; -> CAPTURE after LEN MAC_EN cycles.
//   CAPTURE: MAC_EN=0, so the mac holds its value. The first CAPTURE cycle is one
//    cycle after the last MAC_EN, so ACC_IN is final. If FULL=0, push requant(ACC_IN)
//    and go to IDLE. Otherwise stay in CAPTURE; the accumulator is held and no data
//    is lost.
//  Latency: START to OUT_VALID = LEN+3 cycles when the FIFO is empty.
//  Requant, in ACC_W+1 bits signed:
//   r = (ACC_IN + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >>> SHIFT, with round-half-up.
//   Saturate r to the OUT_W signed range [-128,127]; activation per CONFIGURATION.
//  FIFO: push and pop in the same cycle with 0<count<DEPTH leaves count unchanged.
//   A pop while empty is ignored. A push while full never occurs (CAPTURE stalls).
//   Pointers wrap modulo FIFO_DEPTH. OUT_DATA holds stable while OUT_VALID&!OUT_READY.
//  START during BUSY=1 is ignored, with no effect on counter or latched values.
// CONFIGURATION
//  MAC_READOUT_RELU_EN defined: ReLU applied after saturation; output range [0,127].
//  Undefined: no activation; output range [-128,127]. The FSM and FIFO are identical.
// TESTING
//  1 mac with BIAS_IN=5, a=2, b=3; START with LEN=3, SHIFT=2 -> ACC=23, OUT_DATA=6,
//    OUT_VALID at cycle 6 after START, MAC_EN high exactly 3 cycles.
//  2 ACC_IN=0x7FFF, SHIFT=0 -> 127. ACC_IN=0x8000, SHIFT=0 -> -128 without macro,
//    0 with MAC_READOUT_RELU_EN.
//  3 ACC_IN=-100, SHIFT=1 -> -50 without macro, 0 with macro. ACC_IN=7, SHIFT=1 -> 4.
//  4 LEN=0, BIAS_IN=9, SHIFT=0 -> 0 MAC_EN cycles, OUT_DATA=9.
//  5 OUT_READY=0, run 5 neurons -> FULL after 4, 5th holds in CAPTURE with BUSY=1.
//    Raise OUT_READY -> 5 results emerge in order, none lost or duplicated.
//  6 Assert RST during ACCUM -> all outputs at reset values next edge; no push.
//    START is ignored while BUSY=1.

Source files
------------

// File: rtl/mac_readout.sv
// mac_readout: sequencer and result reader for one mac neuron lane.
// On START it issues a bias preload (MAC_RST) and LEN accumulate cycles (MAC_EN).
// It then requantizes the signed accumulator to an OUT_W activation and queues it
// in a small show-ahead FIFO with a valid/ready output.
// Optional feature: define MAC_READOUT_RELU_EN to clamp negative activations to 0.
module mac_readout #(
  parameter int ACC_W      = 16,
  parameter int OUT_W      = 8,
  parameter int LEN_W      = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             CLKEXT,
  input  logic             RST,
  input  logic             START,
  input  logic [LEN_W-1:0] LEN,
  input  logic [3:0]       SHIFT_IN,
  input  logic [ACC_W-1:0] ACC_IN,
  output logic             MAC_RST,
  output logic             MAC_EN,
  output logic             BUSY,
  output logic [OUT_W-1:0] OUT_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             FULL
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, PRELOAD, ACCUM, CAPTURE} state_t;

  state_t           state, next_state;
  logic [LEN_W-1:0] cnt;
  logic [3:0]       shift_q;

  logic             push, pop;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic [OUT_W-1:0] mem [FIFO_DEPTH];
  logic [OUT_W-1:0] act;

  // State register plus the product down-counter and latched requant shift.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLKEXT or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      shift_q <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && START) begin
        cnt     <= LEN;
        shift_q <= SHIFT_IN;
      end else if (state == ACCUM) begin
        cnt <= cnt - LEN_W'(1);
      end
    end
  end

  // Next-state logic; CAPTURE waits for FIFO space so the held accumulator is never lost.
  // NOTE: next_state gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (START) next_state = PRELOAD;
      PRELOAD: next_state = (cnt != '0) ? ACCUM : CAPTURE;
      ACCUM:   if (cnt == LEN_W'(1)) next_state = CAPTURE;
      CAPTURE: if (!FULL) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Moore outputs decoded from the state register only.
  always_comb begin
    MAC_RST = (state == PRELOAD);
    MAC_EN  = (state == ACCUM);
    BUSY    = (state != IDLE);
  end

  // Requantize: round-half-up, arithmetic shift, saturate, optional ReLU.
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

  logic signed [ACC_W:0] acc_ext, rnd, sum, shifted;

  always_comb begin
    acc_ext = $signed({ACC_IN[ACC_W-1], ACC_IN});
    rnd     = '0;
    if (shift_q != 4'd0) rnd[shift_q - 4'd1] = 1'b1;
    sum     = acc_ext + rnd;
    shifted = sum >>> shift_q;
    if (shifted > SAT_MAX)      act = SAT_MAX[OUT_W-1:0];
    else if (shifted < SAT_MIN) act = SAT_MIN[OUT_W-1:0];
    else                        act = shifted[OUT_W-1:0];
`ifdef MAC_READOUT_RELU_EN
    if (act[OUT_W-1]) act = '0;
`else
`endif
  end

  assign push = (state == CAPTURE) && !FULL;
  assign pop  = OUT_VALID && OUT_READY;

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge CLKEXT or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage write port.
  // NOTE: the storage array is not reset; OUT_DATA is gated by occupancy instead,
  // so stale entries are never visible.
  always_ff @(posedge CLKEXT) begin
    if (push) mem[wr_ptr] <= act;
  end

  assign OUT_VALID = (count != '0);
  assign FULL      = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign OUT_DATA  = OUT_VALID ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_mac_readout.sv
// Testbench for mac_readout: behavioural mac model drives ACC_IN, a scoreboard
// queue holds expected activations, and a monitor compares each handshake.
module tb_mac_readout;

  logic        clk = 1'b0;
  logic        rst, start, out_ready;
  logic        mac_rst, mac_en, busy, out_valid, full;
  logic [9:0]  len;
  logic [3:0]  shift_in;
  logic [15:0] acc_in;
  logic [7:0]  out_data;

  int n_tests = 0;
  int n_fail  = 0;
  int n_push  = 0;
  int n_pop   = 0;
  int en_cnt  = 0;
  int sb[$];
  int exp_v;

  logic signed [15:0] mac_bias = '0, mac_a = '0, mac_b = '0, acc_model;

  always #5 clk = ~clk;

  mac_readout dut (
    .CLKEXT   (clk),
    .RST      (rst),
    .START    (start),
    .LEN      (len),
    .SHIFT_IN (shift_in),
    .ACC_IN   (acc_in),
    .MAC_RST  (mac_rst),
    .MAC_EN   (mac_en),
    .BUSY     (busy),
    .OUT_DATA (out_data),
    .OUT_VALID(out_valid),
    .OUT_READY(out_ready),
    .FULL     (full)
  );

  // Behavioural mac: bias preload on MAC_RST, multiply-accumulate on MAC_EN.
  always @(posedge clk or posedge rst) begin
    if (rst)         acc_model <= '0;
    else if (mac_rst) acc_model <= mac_bias;
    else if (mac_en)  acc_model <= acc_model + mac_a * mac_b;
  end
  assign acc_in = acc_model;

  always @(posedge clk) if (!rst && mac_en) en_cnt <= en_cnt + 1;

  task automatic check(input string tag, input int got, input int want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  function automatic int requant_model(input int acc, input int sh);
    int r;
    r = acc;
    if (sh > 0) r = r + (1 << (sh - 1));
    r = r >>> sh;
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
`ifdef MAC_READOUT_RELU_EN
    if (r < 0) r = 0;
`endif
    return r;
  endfunction

  // Monitor: every accepted output is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_pop++;
      if (sb.size() == 0) begin
        check("spurious_out", out_valid, 0);
      end else begin
        exp_v = sb.pop_front();
        check("sb_data", $signed(out_data), exp_v);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (!busy) break;
      tick();
    end
    if (busy) check("idle_timeout", busy, 0);
  endtask

  // Drive a one-cycle START; optionally push the expected activation.
  task automatic start_neuron(input int l, input int sh, input int bias,
                              input int a, input int b, input bit push_exp);
    logic signed [15:0] acc16;
    mac_bias = 16'(bias);
    mac_a    = 16'(a);
    mac_b    = 16'(b);
    len      = 10'(l);
    shift_in = 4'(sh);
    start    = 1'b1;
    acc16    = 16'(bias + l * a * b);
    if (push_exp) begin
      sb.push_back(requant_model(int'(acc16), sh));
      n_push++;
    end
    tick();
    start = 1'b0;
  endtask

  task automatic measure_latency(input string tag, input int want);
    int n;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (out_valid) begin
        n = i;
        break;
      end
    end
    check(tag, n, want);
  endtask

  initial begin
    int en0;
    bit seen;
    rst = 1'b1; start = 1'b0; out_ready = 1'b1; len = '0; shift_in = '0;
    tick(); tick();
    check("rst_mac_rst", mac_rst, 0);
    check("rst_mac_en", mac_en, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_full", full, 0);
    check("rst_data", out_data, 0);
    rst = 1'b0;
    tick();

    // 1: bias 5, 2*3 three times, shift 2 -> 23 -> 6 at cycle 6
    en0 = en_cnt;
    start_neuron(3, 2, 5, 2, 3, 1'b1);
    measure_latency("t1_latency", 5);
    check("t1_data", $signed(out_data), 6);
    wait_idle();
    tick();
    check("t1_en_cycles", en_cnt - en0, 3);

    // 2/3: direct accumulator values via LEN=0 bias preload
    wait_idle(); start_neuron(0, 0, 16'h7FFF, 0, 0, 1'b1);
    wait_idle(); start_neuron(0, 0, 16'h8000, 0, 0, 1'b1);
    wait_idle(); start_neuron(0, 1, -100, 0, 0, 1'b1);
    wait_idle(); start_neuron(0, 1, 7, 0, 0, 1'b1);
    wait_idle(); start_neuron(2, 15, 16'h4000, 16'h1000, 2, 1'b1);
    wait_idle(); start_neuron(5, 3, -7, -3, 4, 1'b1);

    // 4: LEN=0, bias 9 -> 9 with no MAC_EN cycles, OUT_VALID at cycle 3
    wait_idle();
    repeat (4) tick();
    en0 = en_cnt;
    start_neuron(0, 0, 9, 0, 0, 1'b1);
    measure_latency("t4_latency", 2);
    check("t4_data", $signed(out_data), 9);
    wait_idle();
    tick();
    check("t4_en_cycles", en_cnt - en0, 0);

    // 6a: START during BUSY is ignored
    wait_idle();
    en0 = en_cnt;
    start_neuron(4, 0, 20, 1, 1, 1'b1);
    tick();
    len = 10'd1; shift_in = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle();
    tick();
    check("t6_ignored_en", en_cnt - en0, 4);
    repeat (4) tick();

    // 6b: reset during ACCUM abandons the neuron
    start_neuron(10, 0, 50, 1, 1, 1'b0);
    repeat (3) tick();
    check("t6_in_accum", mac_en, 1);
    rst = 1'b1;
    tick();
    check("t6_rst_mac_en", mac_en, 0);
    check("t6_rst_mac_rst", mac_rst, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_full", full, 0);
    check("t6_rst_data", out_data, 0);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("t6_no_push", seen, 0);

    // 5: back-pressure, FIFO fills after 4, fifth stalls in CAPTURE
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      wait_idle();
      start_neuron(1, 0, 10 * i, 1, 1, 1'b1);
    end
    wait_idle();
    tick();
    check("t5_full", full, 1);
    start_neuron(1, 0, 50, 1, 1, 1'b1);
    repeat (8) tick();
    check("t5_busy_stall", busy, 1);
    check("t5_still_full", full, 1);
    check("t5_mac_en_off", mac_en, 0);
    out_ready = 1'b1;

    // Drain and account for every result
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0 && !out_valid && !busy) break;
      tick();
    end
    repeat (5) tick();
    check("drain_queue", sb.size(), 0);
    check("pop_count", n_pop, n_push);
    check("final_valid", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
